dse_reset_ctrl: RTL and testbench
=================================

Name: dse_reset_ctrl

Overview:
DUT-side initiator of the DSE reset protocol; it drives dse_reset_valid, dse_reset_vector and dse_epoch toward the simulation endpoint that consumes them. It counts committed instructions per epoch. On budget exhaustion or a manual trigger it:
- drains the core,
- freezes perf counters,
- pulses dse_reset_valid for a fixed window,
- advances the epoch.

Software programs it through a small register port.

Parameters:
RESET_CYCLES, 16, cycles dse_reset_valid stays high per reset (>=1)
HOLD_CYCLES, 2, cycles vector/epoch stay stable after valid falls (>=2)
DRAIN_TIMEOUT, 1024, cycles to wait for quiesce_ack (only with macro)

Ports:
clock  in  1  clock
reset  in  1  reset
cfg_wen  in  1  register write strobe
cfg_addr  in  2  register select: 0 CTRL, 1 LIMIT, 2 VECTOR, 3 EPOCH
cfg_wdata  in  64  write data
cfg_rdata  out  64  combinational read of cfg_addr
commit_cnt  in  4  instructions committed this cycle (0..15)
quiesce_ack  in  1  core drained, level
drain_req  out  1  request core drain
perf_freeze  out  1  freeze performance counters
dse_reset_valid  out  1  DSE reset window
dse_reset_vector  out  36  restart PC for next epoch
dse_epoch  out  64  current epoch number

Behaviour:
- Reset is synchronous and active-high; clock is clock. On reset:
  - state IDLE;
  - all outputs 0;
  - epoch, limit, pending vector, instr_cnt and timeout flag all 0.
- Registers:
  - CTRL: bit0 enable (RW); bit1 trigger (write-1, self-clearing, reads 0); bit2 timeout sticky (read-only, write-1-clear).
  - LIMIT: 64-bit RW.
  - VECTOR: low 36 bits RW into pending_vec; upper bits read 0.
  - EPOCH: read-only dse_epoch; writes are ignored.
- States: IDLE, RUN, DRAIN, RESET, HOLD.
- IDLE:
  - enable=1 -> RUN next cycle.
  - instr_cnt is held.
  - trigger is ignored.
- RUN:
  - instr_cnt += commit_cnt, 64-bit, saturating.
  - If LIMIT!=0 and instr_cnt+commit_cnt >= LIMIT in cycle N, or a trigger write lands in cycle N: state=DRAIN in cycle N+1, with drain_req=1 and perf_freeze=1.
  - dse_reset_vector <= pending_vec on that same transition. VECTOR writes after this point affect only the following epoch.
  - enable cleared (with no trigger) -> IDLE.
  - Trigger beats enable-clear in the same cycle.
- DRAIN:
  - quiesce_ack=1 -> RESET next cycle, and dse_epoch <= dse_epoch+1 (wraps at 2^64) on that edge.
  - dse_reset_valid rises with the new epoch already valid.
- RESET:
  - dse_reset_valid=1 for exactly RESET_CYCLES cycles, then -> HOLD.
  - quiesce_ack is ignored.
- HOLD:
  - dse_reset_valid=0 for HOLD_CYCLES cycles.
  - dse_reset_vector and dse_epoch are unchanged through HOLD (the endpoint samples them two edges after the fall).
  - Exit: instr_cnt <= 0; drain_req=0 and perf_freeze=0; state -> RUN if enable else IDLE.
- Enable cleared during DRAIN/RESET/HOLD: the sequence completes, then IDLE.
- dse_reset_vector and dse_epoch change only on the DRAIN entry / RESET entry edges.
- Reset asserted mid-sequence: everything returns to reset values immediately, including dse_reset_valid=0. No HOLD is performed.
- dse_reset_valid never glitches. There is at least HOLD_CYCLES low time between pulses, so the endpoint sees exactly one rising and one falling edge per epoch.

Optional Feature:
DSE_RESET_CTRL_DRAIN_TIMEOUT_EN
- Defined: a DRAIN counter starts on DRAIN entry. If quiesce_ack is not seen within DRAIN_TIMEOUT cycles, the block forces RESET (epoch+1 as normal) and sets CTRL bit2.
- Undefined: DRAIN waits on quiesce_ack indefinitely; CTRL bit2 reads 0; DRAIN_TIMEOUT is unused.

Test Plan:
- Budget trigger: LIMIT=100, enable=1, commit_cnt=4 every cycle. Required: DRAIN entered the cycle after cumulative count reaches 100 (25th commit cycle). With quiesce_ack=1, dse_reset_valid is high 16 cycles then low, dse_epoch goes 0->1 on the rising edge, instr_cnt then reads 0 in RUN.
- Vector shadowing: VECTOR=0x80000000 before trigger, VECTOR=0x1234 written during RESET. Required: dse_reset_vector=0x80000000 through the whole pulse and HOLD; the next epoch uses 0x1234.
- Manual trigger with LIMIT=0: commit_cnt never triggers. CTRL write 0x3 -> DRAIN next cycle, epoch 1. A second trigger after HOLD -> epoch 2, with >=2 low cycles between the pulses.
- Drain stall: quiesce_ack held 0 for 500 cycles then 1. Required: drain_req and perf_freeze high throughout, valid low until the cycle after ack. With the macro and DRAIN_TIMEOUT=64 and ack never asserted: RESET entered after 64 cycles, CTRL bit2=1.
- Enable clear: clear enable during the RESET window. Required: pulse completes with full length and HOLD, then IDLE with drain_req=0; commit_cnt is then ignored.
- Mid-sequence reset: assert reset on the 5th cycle of dse_reset_valid. Required: the next cycle shows valid=0, epoch=0, vector=0, drain_req=0, state IDLE.

Source files
------------

// File: rtl/dse_reset_ctrl.sv
// dse_reset_ctrl: DUT-side initiator of the DSE reset protocol.
// Counts committed instructions per epoch. On budget exhaustion or a manual
// trigger it drains the core, freezes perf counters, pulses dse_reset_valid
// for RESET_CYCLES, holds vector/epoch stable for HOLD_CYCLES, and then
// resumes in the next epoch.
// Optional build macro: DSE_RESET_CTRL_DRAIN_TIMEOUT_EN adds a DRAIN watchdog
// that forces RESET after DRAIN_TIMEOUT cycles and sets sticky CTRL bit2.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | disabled, instruction count held, triggers ignored
// ST_RUN   | counting commits, watching budget and trigger
// ST_DRAIN | drain_req/perf_freeze high, waiting for quiesce_ack
// ST_RESET | dse_reset_valid high for RESET_CYCLES
// ST_HOLD  | valid low, vector/epoch held for HOLD_CYCLES, then resume
module dse_reset_ctrl #(
  parameter int RESET_CYCLES  = 16,
  parameter int HOLD_CYCLES   = 2,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cfg_wen,
  input  logic [1:0]  cfg_addr,
  input  logic [63:0] cfg_wdata,
  output logic [63:0] cfg_rdata,
  input  logic [3:0]  commit_cnt,
  input  logic        quiesce_ack,
  output logic        drain_req,
  output logic        perf_freeze,
  output logic        dse_reset_valid,
  output logic [35:0] dse_reset_vector,
  output logic [63:0] dse_epoch
);

  // One shared wait counter, sized for the largest wait the block can be built with.
  localparam int CNT_MAX_RH = (RESET_CYCLES > HOLD_CYCLES) ? RESET_CYCLES : HOLD_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_RH > DRAIN_TIMEOUT) ? CNT_MAX_RH : DRAIN_TIMEOUT;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_RESET,
    ST_HOLD
  } state_t;

  state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [63:0] instr_cnt;
  logic [63:0] limit;
  logic [35:0] pending_vec;
  logic        enable;
  logic        timeout_flag;

  logic        ctrl_wr;
  logic        trig_wr;
  logic [64:0] sum_ext;
  logic [63:0] sum_sat;
  logic        budget_hit;
  logic        drain_done;

  assign ctrl_wr    = cfg_wen && (cfg_addr == 2'd0);
  assign trig_wr    = ctrl_wr && cfg_wdata[1];
  assign sum_ext    = {1'b0, instr_cnt} + {61'd0, commit_cnt};
  assign sum_sat    = sum_ext[64] ? {64{1'b1}} : sum_ext[63:0];
  assign budget_hit = (limit != '0) && (sum_sat >= limit);

`ifdef DSE_RESET_CTRL_DRAIN_TIMEOUT_EN
  assign drain_done = quiesce_ack || (cnt == '0);
`else
  assign drain_done = quiesce_ack;
  assign timeout_flag = 1'b0;
`endif

  // Software-visible configuration registers (EPOCH is read-only, trigger is a pulse).
  always_ff @(posedge clock) begin
    if (reset) begin
      enable      <= 1'b0;
      limit       <= '0;
      pending_vec <= '0;
    end else if (cfg_wen) begin
      case (cfg_addr)
        2'd0:    enable      <= cfg_wdata[0];
        2'd1:    limit       <= cfg_wdata;
        2'd2:    pending_vec <= cfg_wdata[35:0];
        default: ;
      endcase
    end
  end

  // Sequencer: commit counting, drain, reset pulse, hold, epoch advance.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      instr_cnt        <= '0;
      drain_req        <= 1'b0;
      perf_freeze      <= 1'b0;
      dse_reset_valid  <= 1'b0;
      dse_reset_vector <= '0;
      dse_epoch        <= '0;
`ifdef DSE_RESET_CTRL_DRAIN_TIMEOUT_EN
      timeout_flag     <= 1'b0;
`endif
    end else begin
`ifdef DSE_RESET_CTRL_DRAIN_TIMEOUT_EN
      // Write-1-clear; a timeout in the same cycle below still wins.
      if (ctrl_wr && cfg_wdata[2]) timeout_flag <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (enable) state <= ST_RUN;
        end
        ST_RUN: begin
          instr_cnt <= sum_sat;
          // A trigger wins over a simultaneous enable clear.
          if (trig_wr || budget_hit) begin
            state            <= ST_DRAIN;
            drain_req        <= 1'b1;
            perf_freeze      <= 1'b1;
            dse_reset_vector <= pending_vec;
            cnt              <= CNT_W'(DRAIN_TIMEOUT - 1);
          end else if (!enable) begin
            state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state           <= ST_RESET;
            dse_epoch       <= dse_epoch + 64'd1;
            dse_reset_valid <= 1'b1;
            cnt             <= CNT_W'(RESET_CYCLES - 1);
`ifdef DSE_RESET_CTRL_DRAIN_TIMEOUT_EN
            if (!quiesce_ack) timeout_flag <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
`endif
          end
        end
        ST_RESET: begin
          if (cnt == '0) begin
            state           <= ST_HOLD;
            dse_reset_valid <= 1'b0;
            cnt             <= CNT_W'(HOLD_CYCLES - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            state       <= enable ? ST_RUN : ST_IDLE;
            instr_cnt   <= '0;
            drain_req   <= 1'b0;
            perf_freeze <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Combinational register read-back.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0:    cfg_rdata = {61'd0, timeout_flag, 1'b0, enable};
      2'd1:    cfg_rdata = limit;
      2'd2:    cfg_rdata = {28'd0, pending_vec};
      default: cfg_rdata = dse_epoch;
    endcase
  end

endmodule

// File: tb/tb_dse_reset_ctrl.sv
// Directed bench for dse_reset_ctrl: budget trigger, vector shadowing,
// manual trigger, drain stall / timeout, enable clear, mid-sequence reset.
module tb_dse_reset_ctrl;

`ifdef DSE_RESET_CTRL_DRAIN_TIMEOUT_EN
  localparam int TB_DRAIN_TIMEOUT = 64;
  localparam int STALL_CYCLES     = 60;
`else
  localparam int TB_DRAIN_TIMEOUT = 1024;
  localparam int STALL_CYCLES     = 500;
`endif

  logic        clock;
  logic        reset;
  logic        cfg_wen;
  logic [1:0]  cfg_addr;
  logic [63:0] cfg_wdata;
  logic [63:0] cfg_rdata;
  logic [3:0]  commit_cnt;
  logic        quiesce_ack;
  logic        drain_req;
  logic        perf_freeze;
  logic        dse_reset_valid;
  logic [35:0] dse_reset_vector;
  logic [63:0] dse_epoch;

  int          tests_run;
  int          tests_failed;
  logic [63:0] exp_epoch;

  dse_reset_ctrl #(
    .RESET_CYCLES (16),
    .HOLD_CYCLES  (2),
    .DRAIN_TIMEOUT(TB_DRAIN_TIMEOUT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .cfg_wen         (cfg_wen),
    .cfg_addr        (cfg_addr),
    .cfg_wdata       (cfg_wdata),
    .cfg_rdata       (cfg_rdata),
    .commit_cnt      (commit_cnt),
    .quiesce_ack     (quiesce_ack),
    .drain_req       (drain_req),
    .perf_freeze     (perf_freeze),
    .dse_reset_valid (dse_reset_valid),
    .dse_reset_vector(dse_reset_vector),
    .dse_epoch       (dse_epoch)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [63:0] d);
    cfg_wen   = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_wen   = 1'b0;
    cfg_addr  = 2'd0;
    cfg_wdata = '0;
  endtask

  // Drive quiesce_ack and run the current sequence out until drain_req drops.
  task automatic finish_seq(output bit ok);
    quiesce_ack = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!drain_req) break;
      tick();
    end
    ok = !drain_req;
    quiesce_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_wen = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
    commit_cnt = 4'd0; quiesce_ack = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    tests_run++;
    if ({drain_req, perf_freeze, dse_reset_valid} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_ctl: got %b expected 000", {drain_req, perf_freeze, dse_reset_valid});
    end
    tests_run++;
    if (dse_reset_vector !== 36'd0 || dse_epoch !== 64'd0) begin
      tests_failed++; $display("FAIL reset_vec_epoch: got %0h/%0h expected 0/0", dse_reset_vector, dse_epoch);
    end
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a);
      #1;
      tests_run++;
      if (cfg_rdata !== 64'd0) begin
        tests_failed++; $display("FAIL reset_reg%0d: got %0h expected 0", a, cfg_rdata);
      end
    end
    cfg_addr = 2'd0;
    exp_epoch = 64'd0;
  endtask

  task automatic test_budget();
    int n;
    int hi;
    bit ok;
    cfg_write(2'd3, 64'hDEAD);
    cfg_addr = 2'd3; #1;
    tests_run++;
    if (cfg_rdata !== 64'd0) begin
      tests_failed++; $display("FAIL epoch_ro: got %0h expected 0", cfg_rdata);
    end
    cfg_write(2'd1, 64'd100);
    cfg_addr = 2'd1; #1;
    tests_run++;
    if (cfg_rdata !== 64'd100) begin
      tests_failed++; $display("FAIL limit_rw: got %0d expected 100", cfg_rdata);
    end
    commit_cnt = 4'd4;
    cfg_write(2'd0, 64'd1);
    #1;
    tests_run++;
    if (cfg_rdata !== 64'd1) begin
      tests_failed++; $display("FAIL ctrl_en: got %0h expected 1", cfg_rdata);
    end
    n = 0;
    while (!drain_req && n < 100) begin tick(); n++; end
    // one cycle IDLE->RUN, then 25 commit cycles of 4 reach 100
    tests_run++;
    if (n !== 26) begin
      tests_failed++; $display("FAIL budget_latency: got %0d expected 26", n);
    end
    tests_run++;
    if (perf_freeze !== 1'b1 || dse_reset_valid !== 1'b0 || dse_epoch !== 64'd0) begin
      tests_failed++; $display("FAIL drain_entry: got pf=%b v=%b ep=%0h expected 1 0 0", perf_freeze, dse_reset_valid, dse_epoch);
    end
    quiesce_ack = 1'b1;
    tick();
    exp_epoch = 64'd1;
    tests_run++;
    if (dse_reset_valid !== 1'b1 || dse_epoch !== exp_epoch) begin
      tests_failed++; $display("FAIL reset_rise: got v=%b ep=%0h expected 1 %0h", dse_reset_valid, dse_epoch, exp_epoch);
    end
    quiesce_ack = 1'b0;
    hi = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dse_reset_valid) hi++;
      else break;
    end
    tests_run++;
    if (hi !== 16) begin
      tests_failed++; $display("FAIL pulse_len: got %0d expected 16", hi);
    end
    tests_run++;
    if (drain_req !== 1'b1 || dse_epoch !== exp_epoch) begin
      tests_failed++; $display("FAIL hold1: got dr=%b ep=%0h expected 1 %0h", drain_req, dse_epoch, exp_epoch);
    end
    tick();
    tests_run++;
    if (drain_req !== 1'b1 || dse_reset_valid !== 1'b0) begin
      tests_failed++; $display("FAIL hold2: got dr=%b v=%b expected 1 0", drain_req, dse_reset_valid);
    end
    tick();
    tests_run++;
    if (drain_req !== 1'b0 || perf_freeze !== 1'b0) begin
      tests_failed++; $display("FAIL hold_exit: got dr=%b pf=%b expected 0 0", drain_req, perf_freeze);
    end
    n = 0;
    while (!drain_req && n < 100) begin tick(); n++; end
    tests_run++;
    if (n !== 25) begin
      tests_failed++; $display("FAIL cnt_cleared: got %0d expected 25", n);
    end
    commit_cnt = 4'd0;
    cfg_write(2'd1, 64'd0);
    finish_seq(ok);
    exp_epoch = 64'd2;
    tests_run++;
    if (!ok || dse_epoch !== exp_epoch) begin
      tests_failed++; $display("FAIL budget_epoch2: got ok=%b ep=%0h expected 1 %0h", ok, dse_epoch, exp_epoch);
    end
  endtask

  task automatic test_vector_shadow();
    bit bad;
    bit ok;
    cfg_write(2'd2, 64'hFFFF_FFF0_8000_0000);
    cfg_addr = 2'd2; #1;
    tests_run++;
    if (cfg_rdata !== 64'h8000_0000) begin
      tests_failed++; $display("FAIL vector_rd: got %0h expected 80000000", cfg_rdata);
    end
    cfg_write(2'd0, 64'd3);
    tests_run++;
    if (drain_req !== 1'b1 || dse_reset_vector !== 36'h0_8000_0000) begin
      tests_failed++; $display("FAIL shadow_latch: got dr=%b vec=%0h expected 1 80000000", drain_req, dse_reset_vector);
    end
    quiesce_ack = 1'b1;
    tick();
    quiesce_ack = 1'b0;
    exp_epoch = exp_epoch + 64'd1;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!drain_req) break;
      if (dse_reset_vector !== 36'h0_8000_0000) bad = 1'b1;
      if (i == 3) cfg_write(2'd2, 64'h1234);
      else tick();
    end
    tests_run++;
    if (bad || dse_reset_vector !== 36'h0_8000_0000 || drain_req !== 1'b0) begin
      tests_failed++; $display("FAIL shadow_hold: got bad=%b vec=%0h dr=%b expected 0 80000000 0", bad, dse_reset_vector, drain_req);
    end
    cfg_write(2'd0, 64'd3);
    tests_run++;
    if (dse_reset_vector !== 36'h1234) begin
      tests_failed++; $display("FAIL shadow_next: got %0h expected 1234", dse_reset_vector);
    end
    finish_seq(ok);
    exp_epoch = exp_epoch + 64'd1;
    tests_run++;
    if (!ok || dse_epoch !== exp_epoch) begin
      tests_failed++; $display("FAIL shadow_epoch: got ok=%b ep=%0h expected 1 %0h", ok, dse_epoch, exp_epoch);
    end
  endtask

  task automatic test_manual_trigger();
    bit bad;
    bit sent;
    bit ok;
    int low;
    commit_cnt = 4'd15;
    bad = 1'b0;
    repeat (50) begin tick(); if (drain_req) bad = 1'b1; end
    commit_cnt = 4'd0;
    tests_run++;
    if (bad) begin
      tests_failed++; $display("FAIL limit0_no_budget: got drain_req=1 expected 0");
    end
    cfg_write(2'd0, 64'd3);
    tests_run++;
    if (drain_req !== 1'b1) begin
      tests_failed++; $display("FAIL manual_drain: got %b expected 1", drain_req);
    end
    quiesce_ack = 1'b1;
    tick();
    exp_epoch = exp_epoch + 64'd1;
    tests_run++;
    if (dse_reset_valid !== 1'b1 || dse_epoch !== exp_epoch) begin
      tests_failed++; $display("FAIL manual_epoch: got v=%b ep=%0h expected 1 %0h", dse_reset_valid, dse_epoch, exp_epoch);
    end
    for (int i = 0; i < 40; i++) begin
      if (!dse_reset_valid) break;
      tick();
    end
    low = 0;
    sent = 1'b0;
    while (!dse_reset_valid && low < 50) begin
      low++;
      if (!drain_req && !sent) begin cfg_write(2'd0, 64'd3); sent = 1'b1; end
      else tick();
    end
    exp_epoch = exp_epoch + 64'd1;
    tests_run++;
    if (low < 2 || dse_reset_valid !== 1'b1 || dse_epoch !== exp_epoch) begin
      tests_failed++; $display("FAIL back_to_back: got low=%0d v=%b ep=%0h expected >=2 1 %0h", low, dse_reset_valid, dse_epoch, exp_epoch);
    end
    finish_seq(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL manual_finish: got timeout expected completion");
    end
  endtask

  task automatic test_drain_stall();
    bit bad;
    bit ok;
    cfg_write(2'd0, 64'd3);
    quiesce_ack = 1'b0;
    bad = 1'b0;
    repeat (STALL_CYCLES) begin
      tick();
      if (!drain_req || !perf_freeze || dse_reset_valid) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++; $display("FAIL stall_hold: got bad outputs during stall expected dr=1 pf=1 v=0");
    end
    quiesce_ack = 1'b1;
    tick();
    exp_epoch = exp_epoch + 64'd1;
    tests_run++;
    if (dse_reset_valid !== 1'b1 || dse_epoch !== exp_epoch) begin
      tests_failed++; $display("FAIL stall_release: got v=%b ep=%0h expected 1 %0h", dse_reset_valid, dse_epoch, exp_epoch);
    end
    cfg_addr = 2'd0; #1;
    tests_run++;
    if (cfg_rdata !== 64'd1) begin
      tests_failed++; $display("FAIL stall_ctrl: got %0h expected 1", cfg_rdata);
    end
    finish_seq(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL stall_finish: got timeout expected completion");
    end
  endtask

`ifdef DSE_RESET_CTRL_DRAIN_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    bit ok;
    cfg_write(2'd0, 64'd3);
    quiesce_ack = 1'b0;
    n = 0;
    while (!dse_reset_valid && n < 200) begin tick(); n++; end
    exp_epoch = exp_epoch + 64'd1;
    tests_run++;
    if (n !== 64 || dse_epoch !== exp_epoch) begin
      tests_failed++; $display("FAIL timeout_len: got n=%0d ep=%0h expected 64 %0h", n, dse_epoch, exp_epoch);
    end
    cfg_addr = 2'd0; #1;
    tests_run++;
    if (cfg_rdata !== 64'd5) begin
      tests_failed++; $display("FAIL timeout_flag: got %0h expected 5", cfg_rdata);
    end
    cfg_write(2'd0, 64'd5);
    #1;
    tests_run++;
    if (cfg_rdata !== 64'd1) begin
      tests_failed++; $display("FAIL timeout_w1c: got %0h expected 1", cfg_rdata);
    end
    finish_seq(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL timeout_finish: got timeout expected completion");
    end
  endtask
`endif

  task automatic test_enable_clear();
    int hi;
    bit cleared;
    bit bad;
    cfg_write(2'd0, 64'd3);
    quiesce_ack = 1'b1;
    hi = 0;
    cleared = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (hi == 3 && !cleared) begin cfg_write(2'd0, 64'd0); cleared = 1'b1; end
      else tick();
      if (dse_reset_valid) hi++;
      else if (hi > 0) break;
    end
    quiesce_ack = 1'b0;
    exp_epoch = exp_epoch + 64'd1;
    tests_run++;
    if (hi !== 16 || dse_epoch !== exp_epoch) begin
      tests_failed++; $display("FAIL enclr_pulse: got len=%0d ep=%0h expected 16 %0h", hi, dse_epoch, exp_epoch);
    end
    tick();
    tests_run++;
    if (drain_req !== 1'b1) begin
      tests_failed++; $display("FAIL enclr_hold: got dr=%b expected 1", drain_req);
    end
    tick();
    tests_run++;
    if (drain_req !== 1'b0 || dse_reset_valid !== 1'b0) begin
      tests_failed++; $display("FAIL enclr_exit: got dr=%b v=%b expected 0 0", drain_req, dse_reset_valid);
    end
    cfg_write(2'd1, 64'd1);
    commit_cnt = 4'd15;
    cfg_write(2'd0, 64'd2);
    bad = 1'b0;
    repeat (30) begin tick(); if (drain_req) bad = 1'b1; end
    commit_cnt = 4'd0;
    tests_run++;
    if (bad || dse_epoch !== exp_epoch) begin
      tests_failed++; $display("FAIL enclr_idle: got bad=%b ep=%0h expected 0 %0h", bad, dse_epoch, exp_epoch);
    end
  endtask

  task automatic test_mid_reset();
    cfg_write(2'd1, 64'd0);
    cfg_write(2'd2, 64'hABC);
    cfg_write(2'd0, 64'd1);
    tick();
    cfg_write(2'd0, 64'd3);
    tests_run++;
    if (drain_req !== 1'b1 || dse_reset_vector !== 36'hABC) begin
      tests_failed++; $display("FAIL mid_setup: got dr=%b vec=%0h expected 1 abc", drain_req, dse_reset_vector);
    end
    quiesce_ack = 1'b1;
    tick();
    repeat (4) tick();
    tests_run++;
    if (dse_reset_valid !== 1'b1) begin
      tests_failed++; $display("FAIL mid_valid5: got %b expected 1", dse_reset_valid);
    end
    reset = 1'b1;
    tick();
    exp_epoch = 64'd0;
    tests_run++;
    if ({dse_reset_valid, drain_req, perf_freeze} !== 3'b000 || dse_epoch !== exp_epoch || dse_reset_vector !== 36'd0) begin
      tests_failed++; $display("FAIL mid_reset: got v=%b dr=%b pf=%b ep=%0h vec=%0h expected all 0", dse_reset_valid, drain_req, perf_freeze, dse_epoch, dse_reset_vector);
    end
    reset = 1'b0;
    quiesce_ack = 1'b0;
    repeat (3) tick();
    cfg_addr = 2'd0; #1;
    tests_run++;
    if (dse_reset_valid !== 1'b0 || drain_req !== 1'b0 || cfg_rdata !== 64'd0) begin
      tests_failed++; $display("FAIL mid_idle: got v=%b dr=%b ctrl=%0h expected 0 0 0", dse_reset_valid, drain_req, cfg_rdata);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_budget();
    test_vector_shadow();
    test_manual_trigger();
    test_drain_stall();
`ifdef DSE_RESET_CTRL_DRAIN_TIMEOUT_EN
    test_timeout();
`endif
    test_enable_clear();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
